// File: rtl/cache_miss_fsm.sv
// Miss handler for split I/D caches: dirty write-back, block fills and store replay.
// Define CACHE_CRITICAL_WORD_FIRST_EN to start each fill at the requested word offset.
module cache_miss_fsm #(
   parameter int OFFSET_WIDTH = 3,
   parameter int INDEX_WIDTH  = 6,
   parameter int ADDR_WIDTH   = 30,
   localparam int TAG_WIDTH   = ADDR_WIDTH - OFFSET_WIDTH - INDEX_WIDTH
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    ic_miss,
   input  logic [ADDR_WIDTH-1:0]   ic_addr,
   input  logic                    dc_miss,
   input  logic                    dc_dirty,
   input  logic [TAG_WIDTH-1:0]    dc_victim_tag,
   input  logic [ADDR_WIDTH-1:0]   dc_addr,
   input  logic                    dc_write_in,
   input  logic                    ram_ready,
   output logic                    ram_en,
   output logic                    ram_write,
   output logic [ADDR_WIDTH-1:0]   ram_addr,
   output logic                    ic_fill_we,
   output logic                    dc_fill_we,
   output logic [OFFSET_WIDTH-1:0] word_sel,
   output logic                    dc_replay_we,
   output logic                    mem_stall
);

`ifdef CACHE_CRITICAL_WORD_FIRST_EN
   localparam bit CWF_EN = 1'b1;
`else
   localparam bit CWF_EN = 1'b0;
`endif

   typedef enum logic [2:0] {IDLE, DC_WB, DC_FILL, IC_FILL, REPLAY} state_t;

   state_t                  state_q, state_d;
   logic [OFFSET_WIDTH-1:0] cnt_q, cnt_d, cnt_inc;
   logic                    pend_q, pend_d;
   logic                    leave_idle;
   logic [ADDR_WIDTH-1:0]   ic_addr_q, dc_addr_q;
   logic [TAG_WIDTH-1:0]    vtag_q;
   logic                    ic_miss_q, dc_miss_q;
   logic [OFFSET_WIDTH-1:0] dc_start_in, ic_start_in, dc_start_q, ic_start_q;
   logic                    store_eff;

   // A fill ends on the beat that would bring the counter back to its start offset.
   assign dc_start_in = CWF_EN ? dc_addr[OFFSET_WIDTH-1:0]   : '0;
   assign ic_start_in = CWF_EN ? ic_addr[OFFSET_WIDTH-1:0]   : '0;
   assign dc_start_q  = CWF_EN ? dc_addr_q[OFFSET_WIDTH-1:0] : '0;
   assign ic_start_q  = CWF_EN ? ic_addr_q[OFFSET_WIDTH-1:0] : '0;
   assign cnt_inc     = cnt_q + 1'b1;
   assign store_eff   = pend_q | dc_write_in;
   assign word_sel    = cnt_q;
   assign mem_stall   = (state_q != IDLE) | ic_miss | dc_miss;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         pend_q    <= 1'b0;
         ic_addr_q <= '0;
         dc_addr_q <= '0;
         vtag_q    <= '0;
         ic_miss_q <= 1'b0;
         dc_miss_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         pend_q  <= pend_d;
         if (leave_idle) begin
            ic_addr_q <= ic_addr;
            dc_addr_q <= dc_addr;
            vtag_q    <= dc_victim_tag;
            ic_miss_q <= ic_miss;
            dc_miss_q <= dc_miss;
         end
      end
   end

   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      pend_d       = pend_q;
      leave_idle   = 1'b0;
      ram_en       = 1'b0;
      ram_write    = 1'b0;
      ram_addr     = '0;
      ic_fill_we   = 1'b0;
      dc_fill_we   = 1'b0;
      dc_replay_we = 1'b0;

      if (state_q != IDLE && dc_write_in)
         pend_d = 1'b1;

      case (state_q)
         IDLE: begin
            if (dc_miss) begin
               leave_idle = 1'b1;
               if (dc_dirty) begin
                  state_d = DC_WB;
                  cnt_d   = '0;
               end else begin
                  state_d = DC_FILL;
                  cnt_d   = dc_start_in;
               end
            end else if (ic_miss) begin
               leave_idle = 1'b1;
               state_d    = IC_FILL;
               cnt_d      = ic_start_in;
            end
         end
         DC_WB: begin
            ram_en    = 1'b1;
            ram_write = 1'b1;
            ram_addr  = {vtag_q, dc_addr_q[OFFSET_WIDTH+INDEX_WIDTH-1:OFFSET_WIDTH], cnt_q};
            if (ram_ready) begin
               cnt_d = cnt_inc;
               if (cnt_inc == '0) begin
                  state_d = dc_miss_q ? DC_FILL : IDLE;
                  cnt_d   = dc_miss_q ? dc_start_q : '0;
               end
            end
         end
         DC_FILL: begin
            ram_en     = 1'b1;
            ram_addr   = {dc_addr_q[ADDR_WIDTH-1:OFFSET_WIDTH], cnt_q};
            dc_fill_we = ram_ready;
            if (ram_ready) begin
               cnt_d = cnt_inc;
               if (cnt_inc == dc_start_q) begin
                  if (ic_miss_q) begin
                     state_d = IC_FILL;
                     cnt_d   = ic_start_q;
                  end else begin
                     state_d = store_eff ? REPLAY : IDLE;
                     cnt_d   = '0;
                  end
               end
            end
         end
         IC_FILL: begin
            ram_en     = 1'b1;
            ram_addr   = {ic_addr_q[ADDR_WIDTH-1:OFFSET_WIDTH], cnt_q};
            ic_fill_we = ram_ready;
            if (ram_ready) begin
               cnt_d = cnt_inc;
               if (cnt_inc == ic_start_q) begin
                  state_d = store_eff ? REPLAY : IDLE;
                  cnt_d   = '0;
               end
            end
         end
         REPLAY: begin
            dc_replay_we = 1'b1;
            state_d      = IDLE;
            pend_d       = 1'b0;
         end
         default: state_d = IDLE;
      endcase
   end

endmodule

// File: tb/tb_cache_miss_fsm.sv
// Scoreboard bench for cache_miss_fsm: directed misses, expected beats queued, monitor compares.
module tb_cache_miss_fsm;
   localparam int OW = 3;
   localparam int IW = 6;
   localparam int AW = 30;
   localparam int TW = AW - OW - IW;
   localparam int BS = 1 << OW;

   logic          clk, rst;
   logic          ic_miss, dc_miss, dc_dirty, dc_write_in, ram_ready;
   logic [AW-1:0] ic_addr, dc_addr;
   logic [TW-1:0] dc_victim_tag;
   logic          ram_en, ram_write, ic_fill_we, dc_fill_we, dc_replay_we, mem_stall;
   logic [AW-1:0] ram_addr;
   logic [OW-1:0] word_sel;

   cache_miss_fsm #(.OFFSET_WIDTH(OW), .INDEX_WIDTH(IW), .ADDR_WIDTH(AW)) dut (
      .clk(clk), .rst(rst), .ic_miss(ic_miss), .ic_addr(ic_addr), .dc_miss(dc_miss),
      .dc_dirty(dc_dirty), .dc_victim_tag(dc_victim_tag), .dc_addr(dc_addr),
      .dc_write_in(dc_write_in), .ram_ready(ram_ready), .ram_en(ram_en),
      .ram_write(ram_write), .ram_addr(ram_addr), .ic_fill_we(ic_fill_we),
      .dc_fill_we(dc_fill_we), .word_sel(word_sel), .dc_replay_we(dc_replay_we),
      .mem_stall(mem_stall));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic          en;
      logic          rep;
      logic          wr;
      logic          icwe;
      logic          dcwe;
      logic [AW-1:0] addr;
      logic [OW-1:0] ws;
   } exp_t;

   exp_t q[$];
   exp_t mon_a, mon_e;
   int   n_cmp = 0;
   int   n_bad = 0;
   int   cyc;

   function automatic logic [OW-1:0] start_off(input logic [AW-1:0] a);
`ifdef CACHE_CRITICAL_WORD_FIRST_EN
      return a[OW-1:0];
`else
      return '0;
`endif
   endfunction

   // kind 0 = write-back, 1 = D fill, 2 = I fill; n beats queued
   task automatic push_block(input int kind, input logic [TW-1:0] tag,
                             input logic [AW-1:0] a, input int n);
      logic [OW-1:0] s, o;
      exp_t e;
      s = (kind == 0) ? '0 : start_off(a);
      for (int i = 0; i < n; i++) begin
         o      = s + OW'(i);
         e.en   = 1'b1;
         e.rep  = 1'b0;
         e.wr   = (kind == 0);
         e.dcwe = (kind == 1);
         e.icwe = (kind == 2);
         e.addr = {tag, a[OW+IW-1:OW], o};
         e.ws   = o;
         q.push_back(e);
      end
   endtask

   task automatic push_replay();
      exp_t e;
      e     = '0;
      e.rep = 1'b1;
      q.push_back(e);
   endtask

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Monitor: every accepted RAM beat or replay cycle is popped and compared.
   always @(negedge clk) begin
      if (!rst && ((ram_en && ram_ready) || dc_replay_we)) begin
         mon_a.en   = ram_en;
         mon_a.rep  = dc_replay_we;
         mon_a.wr   = ram_write;
         mon_a.icwe = ic_fill_we;
         mon_a.dcwe = dc_fill_we;
         mon_a.addr = dc_replay_we ? '0 : ram_addr;
         mon_a.ws   = dc_replay_we ? '0 : word_sel;
         n_cmp++;
         if (q.size() == 0) begin
            n_bad++;
            $display("FAIL unexpected_beat: got en=%0b rep=%0b wr=%0b addr=%0h ws=%0d, expected none",
                     mon_a.en, mon_a.rep, mon_a.wr, mon_a.addr, mon_a.ws);
         end else begin
            mon_e = q.pop_front();
            if (mon_a !== mon_e) begin
               n_bad++;
               $display("FAIL beat: got en=%0b rep=%0b wr=%0b icwe=%0b dcwe=%0b addr=%0h ws=%0d, expected en=%0b rep=%0b wr=%0b icwe=%0b dcwe=%0b addr=%0h ws=%0d",
                        mon_a.en, mon_a.rep, mon_a.wr, mon_a.icwe, mon_a.dcwe, mon_a.addr, mon_a.ws,
                        mon_e.en, mon_e.rep, mon_e.wr, mon_e.icwe, mon_e.dcwe, mon_e.addr, mon_e.ws);
            end
         end
      end
   end

   // Issue a miss in IDLE, scramble inputs afterwards, and count non-idle cycles.
   task automatic run_miss(input logic im, input logic dm, input logic dirty,
                           input logic [TW-1:0] vtag, input logic [AW-1:0] ia,
                           input logic [AW-1:0] da, input int store_at,
                           input bit toggle, input bit wr_idle, output int cycles);
      int i;
      ic_miss       = im;
      dc_miss       = dm;
      dc_dirty      = dirty;
      dc_victim_tag = vtag;
      ic_addr       = ia;
      dc_addr       = da;
      dc_write_in   = wr_idle;
      ram_ready     = 1'b1;
      @(negedge clk);
      check("stall_on_miss", mem_stall, 1);
      @(posedge clk); #1;
      ic_miss       = 1'b0;
      dc_miss       = 1'b0;
      dc_dirty      = ~dirty;
      dc_victim_tag = ~vtag;
      ic_addr       = ~ia;
      dc_addr       = ~da;
      dc_write_in   = 1'b0;
      cycles = 0;
      for (i = 0; i < 200; i++) begin
         ram_ready   = toggle ? i[0] : 1'b1;
         dc_write_in = (i == store_at);
         @(negedge clk);
         if (!mem_stall) break;
         cycles++;
         @(posedge clk); #1;
      end
      @(posedge clk); #1;
      ram_ready   = 1'b1;
      dc_write_in = 1'b0;
   endtask

   initial begin
      logic [AW-1:0] da, ia;
      rst = 1'b1;
      ic_miss = 0; dc_miss = 0; dc_dirty = 0; dc_write_in = 0; ram_ready = 0;
      ic_addr = '0; dc_addr = '0; dc_victim_tag = '0;
      repeat (2) @(negedge clk);
      check("reset_outputs", {ram_en, ram_write, ic_fill_we, dc_fill_we, dc_replay_we, word_sel, ram_addr},
            '0);
      check("reset_stall_idle", mem_stall, 0);
      dc_miss = 1'b1;
      #1;
      check("reset_stall_comb", mem_stall, 1);
      dc_miss = 1'b0;
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;

      // clean D miss
      da = 30'h0000123;
      push_block(1, da[AW-1:OW+IW], da, BS);
      run_miss(0, 1, 0, '0, '0, da, -1, 0, 0, cyc);
      check("clean_cycles", cyc, BS);
      check("clean_q_empty", q.size(), 0);

      // dirty D miss: write-back then fill
      da = 30'h1234567;
      push_block(0, 21'h5A, da, BS);
      push_block(1, da[AW-1:OW+IW], da, BS);
      run_miss(0, 1, 1, 21'h5A, '0, da, -1, 0, 0, cyc);
      check("dirty_cycles", cyc, 2 * BS);
      check("dirty_q_empty", q.size(), 0);

      // double miss with store during D fill
      da = 30'h0ABCDE5;
      ia = 30'h2345678;
      push_block(1, da[AW-1:OW+IW], da, BS);
      push_block(2, ia[AW-1:OW+IW], ia, BS);
      push_replay();
      run_miss(1, 1, 0, '0, ia, da, 3, 0, 0, cyc);
      check("double_store_cycles", cyc, 2 * BS + 1);
      check("double_store_q_empty", q.size(), 0);

      // ready toggling during a clean fill
      da = 30'h3000055;
      push_block(1, da[AW-1:OW+IW], da, BS);
      run_miss(0, 1, 0, '0, '0, da, -1, 1, 0, cyc);
      check("toggle_cycles", cyc, 2 * BS);
      check("toggle_q_empty", q.size(), 0);

      // I-only miss, store request while still IDLE must not replay
      ia = 30'h1FFFFFF;
      push_block(2, ia[AW-1:OW+IW], ia, BS);
      run_miss(1, 0, 0, '0, ia, '0, -1, 0, 1, cyc);
      check("ic_only_cycles", cyc, BS);
      check("ic_only_q_empty", q.size(), 0);

      // dirty D miss plus I miss, no store
      da = 30'h2222229;
      ia = 30'h0777772;
      push_block(0, 21'h1F0F0, da, BS);
      push_block(1, da[AW-1:OW+IW], da, BS);
      push_block(2, ia[AW-1:OW+IW], ia, BS);
      run_miss(1, 1, 1, 21'h1F0F0, ia, da, -1, 0, 0, cyc);
      check("double_dirty_cycles", cyc, 3 * BS);
      check("double_dirty_q_empty", q.size(), 0);

      // reset at write-back beat 3 abandons the transaction
      da = 30'h0FEDCBA;
      push_block(0, 21'h1ABCD, da, 3);
      dc_miss = 1'b1; dc_dirty = 1'b1; dc_victim_tag = 21'h1ABCD; dc_addr = da; ram_ready = 1'b1;
      @(posedge clk); #1;
      dc_miss = 1'b0; dc_dirty = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b1;
      @(negedge clk);
      check("rst_mid_ram_en", ram_en, 0);
      check("rst_mid_word_sel", word_sel, 0);
      check("rst_mid_stall", mem_stall, 0);
      @(posedge clk); #1;
      rst = 1'b0;
      repeat (10) @(negedge clk);
      check("rst_after_stall", mem_stall, 0);
      check("rst_q_empty", q.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1, "watchdog");
   end

endmodule
